nios_button_ctrl: RTL and testbench



---
 rtl/nios_button_ctrl_pkg.sv | 14 +
 rtl/nios_button_ctrl_if.sv | 20 ++
 rtl/nios_button_debounce.sv | 99 +++++++++
 rtl/nios_button_ctrl.sv | 129 ++++++++++++
 tb/tb_nios_button_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/nios_button_ctrl_pkg.sv
// rtl/nios_button_ctrl_pkg.sv - shared register map constants and debounce state type
package nios_button_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

endpackage

// File: rtl/nios_button_ctrl_if.sv
// rtl/nios_button_ctrl_if.sv - Avalon-MM slave register bus for the button controller
interface nios_button_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_button_debounce.sv
// rtl/nios_button_debounce.sv - per-button synchroniser, polarity fix and debounce FSM
module nios_button_debounce
    import nios_button_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw,
    input  logic [CNT_W-1:0] period,
    input  logic             clr_cnt,
    output logic             deb,
    output logic             press_pulse
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    db_state_t        r_state;

    logic             w_s;
    logic             w_last;
    logic             w_deb_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    db_state_t        w_state_nxt;

    // two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_last = (r_cnt == (period - CNT_W'(1)));

    // debounce state, counter and accepted level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_deb   <= w_deb_nxt;
        end
    end

    // next state: a new level is accepted after `period` consecutive differing samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_deb_nxt   = r_deb;
        if (clr_cnt) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                STABLE: begin
                    if (w_s != r_deb) begin
                        if (w_last) begin
                            w_deb_nxt = w_s;
                        end else begin
                            w_cnt_nxt   = CNT_W'(1);
                            w_state_nxt = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (w_s == r_deb) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = STABLE;
                    end else if (w_last) begin
                        w_deb_nxt   = w_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STABLE;
                end
            endcase
        end
    end

    assign deb         = r_deb;
    assign press_pulse = w_deb_nxt & ~r_deb;

endmodule

// File: rtl/nios_button_ctrl.sv
// rtl/nios_button_ctrl.sv - debounced push-button controller top; optional auto-repeat under NIOS_BUTTON_CTRL_AUTOREPEAT_EN
module nios_button_ctrl
    import nios_button_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int DB_CYCLES     = 50000,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW    = 1
`ifdef NIOS_BUTTON_CTRL_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_button_ctrl_if.slave    avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [CNT_W-1:0] r_period;
    logic             r_irq;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_wr_period;
    logic [CNT_W-1:0] w_wd_period;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_repeat;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_nxt;
    logic             w_unused;

    assign w_wr        = avs.chipselect & ~avs.write_n;
    assign w_wr_mask   = w_wr & (avs.address == ADDR_MASK);
    assign w_wr_edge   = w_wr & (avs.address == ADDR_EDGE);
    assign w_wr_period = w_wr & (avs.address == ADDR_PERIOD);
    assign w_wd_period = (avs.writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : avs.writedata[CNT_W-1:0];
    assign w_unused    = ^{1'b0, avs.writedata};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_db
            nios_button_debounce #(
                .CNT_W      (CNT_W),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_db (
                .clk         (clk),
                .reset_n     (reset_n),
                .raw         (in_port[gi]),
                .period      (r_period),
                .clr_cnt     (w_wr_period),
                .deb         (w_deb[gi]),
                .press_pulse (w_press[gi])
            );
        end
    endgenerate

`ifdef NIOS_BUTTON_CTRL_AUTOREPEAT_EN
    localparam int HOLD_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [HOLD_W-1:0] r_hold [WIDTH];

    // hold counters re-arm the capture bit while a button stays pressed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_deb[i] || w_repeat[i]) r_hold[i] <= '0;
                else                          r_hold[i] <= r_hold[i] + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < WIDTH; i++)
            w_repeat[i] = w_deb[i] && (r_hold[i] == HOLD_W'(REPEAT_CYCLES - 1));
    end
`else
    assign w_repeat = '0;
`endif

    assign w_set = w_press | w_repeat;
    assign w_clr = w_wr_edge ? avs.writedata[WIDTH-1:0] : '0;

    // register file, sticky capture (set beats clear) and registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= '0;
            r_cap    <= '0;
            r_period <= CNT_W'(DB_CYCLES);
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_mask)   r_mask   <= avs.writedata[WIDTH-1:0];
            if (w_wr_period) r_period <= w_wd_period;
            r_cap <= (r_cap & ~w_clr) | w_set;
            r_irq <= |(r_cap & r_mask);
        end
    end

    // read mux, zero-extended to the bus width
    always_comb begin
        w_rd_nxt = '0;
        case (avs.address)
            ADDR_DATA:   w_rd_nxt[WIDTH-1:0] = w_deb;
            ADDR_MASK:   w_rd_nxt[WIDTH-1:0] = r_mask;
            ADDR_EDGE:   w_rd_nxt[WIDTH-1:0] = r_cap;
            ADDR_PERIOD: w_rd_nxt[CNT_W-1:0] = r_period;
            default:     w_rd_nxt = '0;
        endcase
    end

    // readdata refreshes every cycle from the addressed register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else          r_readdata <= w_rd_nxt;
    end

    assign avs.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_nios_button_ctrl.sv
// tb/tb_nios_button_ctrl.sv - scoreboard bench with behavioural model for nios_button_ctrl
module tb_nios_button_ctrl;

    localparam int W   = 2;
    localparam int REP = 8;

    typedef struct {
        bit [31:0] rd;
        bit        irq;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;
    nios_button_ctrl_if bus();

    always #5 clk = ~clk;

    nios_button_ctrl #(
        .WIDTH      (W),
        .DB_CYCLES  (50000),
        .CNT_W      (16),
        .ACTIVE_LOW (1)
`ifdef NIOS_BUTTON_CTRL_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES (REP)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    exp_t     sb[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    bit [W-1:0] pins;

    int       m_period;
    bit [W-1:0] m_deb, m_cap, m_mask, m_sy1, m_sy2;
    int       m_run[W];
    int       m_hold[W];

    task automatic model_reset();
        m_period = 50000;
        m_deb = '0; m_cap = '0; m_mask = '0; m_sy1 = '0; m_sy2 = '0;
        for (int i = 0; i < W; i++) begin m_run[i] = 0; m_hold[i] = 0; end
    endtask

    task automatic model_step(input bit rst, input bit [W-1:0] p, input bit cs, input bit wn,
                              input bit [1:0] a, input bit [31:0] d);
        exp_t e;
        bit [W-1:0] set;
        bit wr;
        bit s;
        e.rd = 0; e.irq = 0;
        if (rst) begin
            model_reset();
            sb.push_back(e);
            return;
        end
        case (a)
            2'd0: e.rd = 32'(m_deb);
            2'd1: e.rd = 32'(m_mask);
            2'd2: e.rd = 32'(m_cap);
            default: e.rd = 32'(m_period);
        endcase
        e.irq = |(m_cap & m_mask);
        wr  = cs && !wn;
        set = '0;
`ifdef NIOS_BUTTON_CTRL_AUTOREPEAT_EN
        for (int i = 0; i < W; i++) begin
            if (m_deb[i]) begin
                if (m_hold[i] == REP - 1) begin set[i] = 1'b1; m_hold[i] = 0; end
                else m_hold[i]++;
            end else m_hold[i] = 0;
        end
`endif
        for (int i = 0; i < W; i++) begin
            s = ~m_sy2[i];
            if (wr && a == 2'd3) m_run[i] = 0;
            else if (s != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == m_period) begin
                    m_deb[i] = s;
                    m_run[i] = 0;
                    if (s) set[i] = 1'b1;
                end
            end else m_run[i] = 0;
        end
        if (wr && a == 2'd2) m_cap = m_cap & ~d[W-1:0];
        m_cap = m_cap | set;
        if (wr && a == 2'd1) m_mask = d[W-1:0];
        if (wr && a == 2'd3) m_period = (d[15:0] == 0) ? 1 : int'(d[15:0]);
        m_sy2 = m_sy1;
        m_sy1 = p;
        sb.push_back(e);
    endtask

    task automatic do_cycle(input bit cs, input bit wn, input bit [1:0] a, input bit [31:0] d);
        bus.chipselect = cs; bus.write_n = wn; bus.address = a; bus.writedata = d;
        in_port = pins;
        @(posedge clk);
        model_step(!reset_n, pins, cs, wn, a, d);
        cyc++;
        #1;
    endtask

    task automatic rd(input bit [1:0] a);
        do_cycle(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic wr(input bit [1:0] a, input bit [31:0] d);
        do_cycle(1'b1, 1'b0, a, d);
    endtask

    // monitor: compare every registered output against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.readdata !== e.rd) begin
                errors++;
                $display("FAIL readdata cyc=%0d got=%0h exp=%0h", cyc, bus.readdata, e.rd);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL irq cyc=%0d got=%0b exp=%0b", cyc, irq, e.irq);
            end
        end
    end

    initial begin
        bit found;
        pins = '1;
        reset_n = 1'b0;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
        in_port = pins;
        model_reset();
        repeat (3) do_cycle(1'b0, 1'b1, 2'd0, 32'd0);
        reset_n = 1'b1;

        for (int a = 0; a < 4; a++) rd(2'(a));
        rd(2'd0);

        wr(2'd3, 32'd4);
        wr(2'd1, 32'd3);

        pins[0] = 1'b0;
        for (int i = 0; i < 10; i++) rd(2'(i % 2 == 0 ? 0 : 2));

        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pins[1] = ~pins[1];
            rd(2'd2);
        end
        pins[1] = 1'b1;
        repeat (8) rd(2'd0);

        pins[1] = 1'b0;
        repeat (8) rd(2'd2);
        wr(2'd2, 32'd1);
        repeat (2) rd(2'd2);

        pins[1] = 1'b1;
        for (int i = 0; i < 20 && m_deb[1]; i++) rd(2'd0);
        pins[1] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((~m_sy2[1]) != m_deb[1] && m_run[1] + 1 == m_period) begin
                wr(2'd2, 32'd2);
                found = 1'b1;
            end else rd(2'd0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL press_window got=0 exp=1");
        end
        repeat (2) rd(2'd2);

        pins[0] = 1'b1;
        repeat (3) rd(2'd0);
        wr(2'd3, 32'd0);
        for (int i = 0; i < 6; i++) rd(2'(i % 2 == 0 ? 3 : 0));

        wr(2'd3, 32'd2);
        wr(2'd2, 32'd3);
        repeat (4) rd(2'd0);
        pins[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_cap[0]) wr(2'd2, 32'd1);
            else rd(2'd2);
        end
        pins = '1;
        repeat (6) rd(2'd0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                pins = '0;
                @(negedge clk);
                #1;
                reset_n = 1'b0;
                repeat (2) do_cycle(1'b0, 1'b1, 2'd0, 32'd0);
                reset_n = 1'b1;
                wr(2'd3, 32'd3);
                wr(2'd1, 32'd3);
                repeat (8) rd(2'd2);
            end
            if ($urandom_range(0, 7) == 0) pins[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 9) < 7) rd(2'($urandom_range(0, 3)));
            else begin
                case ($urandom_range(0, 3))
                    0: wr(2'd0, $urandom);
                    1: wr(2'd1, $urandom);
                    2: wr(2'd2, $urandom);
                    default: wr(2'd3, 32'($urandom_range(0, 6)));
                endcase
            end
        end

        bus.chipselect = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
